airlock_pressure_ctrl: RTL and testbench
========================================

Name: airlock_pressure_ctrl

Overview:
Parametrised airlock chamber controller that takes the chamber between its evacuated and pressurized conditions in both directions. It models chamber pressure as a level counter stepped at a programmable rate, and enforces the door interlock for the whole operation, not only at start. Door-open during an operation aborts into a latched fault. It sits between the airlock sequencer (start requests) and the door sensors, and drives the pump/valve enables and status flags.

Parameters:
LEVEL_W, 8, width of pressure level counter
MAX_LEVEL, 200, level meaning fully pressurized (must be >0 and < 2^LEVEL_W)
STEP_DIV, 4, clocks per one-level step (>=1)
DIV_W, 8, width of step prescaler counter (STEP_DIV <= 2^DIV_W)

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
start_pressurize  input  1  request fill/pressurize, sampled each clock
start_evacuate  input  1  request evacuate, sampled each clock
InnerClosed  input  1  inner door closed sensor
OuterClosed  input  1  outer door closed sensor
clear_fault  input  1  clears latched fault (FAULT state only)
Pressurizing  output  1  fill valve enable
Evacuating  output  1  vacuum pump enable
Pressurized  output  1  level == MAX_LEVEL
Evacuated  output  1  level == 0
done  output  1  one-cycle pulse on operation completion
fault  output  1  latched interlock fault
level  output  LEVEL_W  current chamber level

Behaviour:
- One clock (Clock); Reset synchronous, active-high; all state updates on rising edge.
- Reset: state=IDLE, level=0, prescaler=0, Pressurizing=0, Evacuating=0, done=0, fault=0; hence Evacuated=1, Pressurized=0. Reset mid-operation returns to these values next edge.
- Doors ok = InnerClosed && OuterClosed.
- States: IDLE, PRESS, EVAC, FAULT. Outputs Moore: Pressurizing=(state==PRESS), Evacuating=(state==EVAC), fault=(state==FAULT).
- IDLE -> PRESS: start_pressurize && !start_evacuate && doors ok && level != MAX_LEVEL.
- IDLE -> EVAC: start_evacuate && !start_pressurize && doors ok && level != 0.
- IDLE, both starts high: ignored, stay IDLE. Start with doors open, or start toward the level already held: ignored, no fault, no done.
- Latency: start sampled high on edge N -> Pressurizing/Evacuating=1 after edge N.
- Prescaler cleared on entry to PRESS/EVAC; increments each cycle in PRESS/EVAC; when it reaches STEP_DIV-1 it wraps to 0 and level steps +1 (PRESS) or -1 (EVAC). First step occurs STEP_DIV cycles after entry.
- PRESS: when the step makes level==MAX_LEVEL, same edge -> IDLE and done=1 for exactly one cycle. EVAC likewise at level==0. Level never exceeds MAX_LEVEL nor goes below 0 (no wrap).
- Starts asserted while in PRESS/EVAC: ignored (no reversal mid-operation).
- PRESS/EVAC with doors not ok on any sampled edge -> FAULT; level and prescaler frozen at current values; no done. Door check has priority over the completing step on the same edge (fault wins, level not updated).
- FAULT: stays until clear_fault=1 and doors ok -> IDLE (level retained, partial). clear_fault with a door open: stay FAULT. Starts ignored in FAULT.
- Pressurized/Evacuated combinational from level; both 0 at partial level.
- done is a registered pulse, deasserts the following cycle regardless of inputs.

Test Plan:
- Bench params MAX_LEVEL=10, STEP_DIV=3. Reset 2 cycles -> level=0, Evacuated=1, all enables/done/fault=0.
- Doors closed, start_pressurize 1 cycle -> Pressurizing=1 next cycle; level increments every 3 cycles; after 30 cycles level=10, done=1 for one cycle, Pressurizing=0, Pressurized=1.
- From level=10, start_evacuate -> Evacuating=1; after 30 cycles level=0, done pulse, Evacuated=1; then start_evacuate again -> ignored, no done.
- Pressurizing from 0, drop OuterClosed at level=4 -> FAULT next edge, fault=1, Pressurizing=0, level holds 4; clear_fault with door open -> stays; close door + clear_fault -> IDLE, level=4, both status flags 0.
- start_pressurize and start_evacuate both high in IDLE -> no state change; start_pressurize with InnerClosed=0 -> no state change, fault=0.
- Reset asserted while in EVAC at level=6 -> next cycle level=0, IDLE, enables 0; door drop and final step on the same edge (level 9->10) -> FAULT, level stays 9, no done.

Source files
------------

// File: rtl/airlock_pressure_ctrl.sv
// Airlock chamber controller: ramps a pressure level counter up or down at a
// prescaled rate, holds the door interlock for the whole operation, and latches a fault if a door opens.
//
// state | meaning
// IDLE  | no operation, level held, waiting for a valid start
// PRESS | fill valve open, level stepping up toward MAX_LEVEL
// EVAC  | vacuum pump on, level stepping down toward 0
// FAULT | door opened mid-operation, level frozen until cleared
module airlock_pressure_ctrl #(
    parameter int LEVEL_W   = 8,
    parameter int MAX_LEVEL = 200,
    parameter int STEP_DIV  = 4,
    parameter int DIV_W     = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               start_pressurize,
    input  logic               start_evacuate,
    input  logic               InnerClosed,
    input  logic               OuterClosed,
    input  logic               clear_fault,
    output logic               Pressurizing,
    output logic               Evacuating,
    output logic               Pressurized,
    output logic               Evacuated,
    output logic               done,
    output logic               fault,
    output logic [LEVEL_W-1:0] level
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PRESS = 2'd1;
    localparam logic [1:0] EVAC  = 2'd2;
    localparam logic [1:0] FAULT = 2'd3;

    localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(MAX_LEVEL);
    localparam logic [LEVEL_W-1:0] LEVEL_ONE = LEVEL_W'(1);
    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(STEP_DIV - 1);
    localparam logic [DIV_W-1:0]   DIV_ONE   = DIV_W'(1);

    logic [1:0]         state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [DIV_W-1:0]   presc_q, presc_d;
    logic               done_q, done_d;
    logic               doors_ok;
    logic               step_now;

    assign doors_ok = InnerClosed && OuterClosed;
    assign step_now = (presc_q == DIV_LAST);

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_pressurize && !start_evacuate && doors_ok && level_q != LEVEL_MAX) begin
                    state_d = PRESS;
                    presc_d = '0;
                end else if (start_evacuate && !start_pressurize && doors_ok && level_q != '0) begin
                    state_d = EVAC;
                    presc_d = '0;
                end
            end
            PRESS: begin
                // Door check outranks the step so a fault never completes the operation.
                if (!doors_ok) begin
                    state_d = FAULT;
                end else if (step_now) begin
                    presc_d = '0;
                    level_d = level_q + LEVEL_ONE;
                    if (level_q + LEVEL_ONE == LEVEL_MAX) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + DIV_ONE;
                end
            end
            EVAC: begin
                if (!doors_ok) begin
                    state_d = FAULT;
                end else if (step_now) begin
                    presc_d = '0;
                    level_d = level_q - LEVEL_ONE;
                    if (level_q == LEVEL_ONE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + DIV_ONE;
                end
            end
            default: begin
                if (clear_fault && doors_ok) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            level_q <= '0;
            presc_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            presc_q <= presc_d;
            done_q  <= done_d;
        end
    end

    assign Pressurizing = (state_q == PRESS);
    assign Evacuating   = (state_q == EVAC);
    assign fault        = (state_q == FAULT);
    assign done         = done_q;
    assign level        = level_q;
    assign Pressurized  = (level_q == LEVEL_MAX);
    assign Evacuated    = (level_q == '0);

endmodule

// File: tb/tb_airlock_pressure_ctrl.sv
// Directed bench for airlock_pressure_ctrl with MAX_LEVEL=10, STEP_DIV=3;
// expected values are hand-computed from the level/prescaler timing.
module tb_airlock_pressure_ctrl;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       start_pressurize, start_evacuate;
    logic       InnerClosed, OuterClosed, clear_fault;
    logic       Pressurizing, Evacuating, Pressurized, Evacuated, done, fault;
    logic [7:0] level;

    int n_tests = 0;
    int n_fail  = 0;

    airlock_pressure_ctrl #(
        .LEVEL_W(8), .MAX_LEVEL(10), .STEP_DIV(3), .DIV_W(8)
    ) dut (
        .Clock(Clock), .Reset(Reset),
        .start_pressurize(start_pressurize), .start_evacuate(start_evacuate),
        .InnerClosed(InnerClosed), .OuterClosed(OuterClosed), .clear_fault(clear_fault),
        .Pressurizing(Pressurizing), .Evacuating(Evacuating),
        .Pressurized(Pressurized), .Evacuated(Evacuated),
        .done(done), .fault(fault), .level(level)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit past the last edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            #1;
        end
    endtask

    initial begin
        Reset = 1'b1;
        start_pressurize = 1'b0;
        start_evacuate   = 1'b0;
        InnerClosed = 1'b1;
        OuterClosed = 1'b1;
        clear_fault = 1'b0;
        tick(2);
        Reset = 1'b0;
        check("rst_level", level, 0);
        check("rst_evacuated", Evacuated, 1);
        check("rst_pressurized", Pressurized, 0);
        check("rst_pressurizing", Pressurizing, 0);
        check("rst_evacuating", Evacuating, 0);
        check("rst_done", done, 0);
        check("rst_fault", fault, 0);

        // Full pressurize 0 -> 10; a mid-run evacuate request must be ignored.
        start_pressurize = 1'b1;
        tick(1);
        start_pressurize = 1'b0;
        check("p_enable", Pressurizing, 1);
        check("p_level0", level, 0);
        start_evacuate = 1'b1;
        tick(3);
        start_evacuate = 1'b0;
        check("p_level1", level, 1);
        check("p_no_reverse", Evacuating, 0);
        check("p_still_on", Pressurizing, 1);
        tick(26);
        check("p_level9", level, 9);
        check("p_no_early_done", done, 0);
        tick(1);
        check("p_level10", level, 10);
        check("p_done", done, 1);
        check("p_enable_off", Pressurizing, 0);
        check("p_pressurized", Pressurized, 1);
        tick(1);
        check("p_done_pulse", done, 0);

        // Full evacuate 10 -> 0, then repeat request is ignored.
        start_evacuate = 1'b1;
        tick(1);
        start_evacuate = 1'b0;
        check("e_enable", Evacuating, 1);
        tick(29);
        check("e_level1", level, 1);
        tick(1);
        check("e_level0", level, 0);
        check("e_done", done, 1);
        check("e_evacuated", Evacuated, 1);
        check("e_enable_off", Evacuating, 0);
        tick(1);
        check("e_done_pulse", done, 0);
        start_evacuate = 1'b1;
        tick(1);
        start_evacuate = 1'b0;
        check("e_repeat_ignored", Evacuating, 0);
        check("e_repeat_no_done", done, 0);

        // Door drop at level 4 -> latched fault with level frozen.
        start_pressurize = 1'b1;
        tick(1);
        start_pressurize = 1'b0;
        tick(12);
        check("f_level4", level, 4);
        OuterClosed = 1'b0;
        tick(1);
        check("f_fault", fault, 1);
        check("f_enable_off", Pressurizing, 0);
        check("f_level_hold", level, 4);
        clear_fault = 1'b1;
        tick(2);
        check("f_clear_door_open", fault, 1);
        check("f_level_hold2", level, 4);
        OuterClosed = 1'b1;
        tick(1);
        clear_fault = 1'b0;
        check("f_cleared", fault, 0);
        check("f_level_kept", level, 4);
        check("f_not_pressurized", Pressurized, 0);
        check("f_not_evacuated", Evacuated, 0);

        // Conflicting starts and door-open starts are ignored.
        start_pressurize = 1'b1;
        start_evacuate   = 1'b1;
        tick(1);
        start_pressurize = 1'b0;
        start_evacuate   = 1'b0;
        check("both_no_press", Pressurizing, 0);
        check("both_no_evac", Evacuating, 0);
        InnerClosed = 1'b0;
        start_pressurize = 1'b1;
        tick(1);
        start_pressurize = 1'b0;
        check("door_open_no_press", Pressurizing, 0);
        check("door_open_no_fault", fault, 0);
        InnerClosed = 1'b1;

        // Pressurize 4 -> 10, evacuate to 6, then reset mid-operation.
        start_pressurize = 1'b1;
        tick(1);
        start_pressurize = 1'b0;
        tick(18);
        check("r_level10", level, 10);
        check("r_done", done, 1);
        start_evacuate = 1'b1;
        tick(1);
        start_evacuate = 1'b0;
        tick(12);
        check("r_level6", level, 6);
        check("r_evacuating", Evacuating, 1);
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        check("r_level0", level, 0);
        check("r_evac_off", Evacuating, 0);
        check("r_evacuated", Evacuated, 1);

        // Door drop on the same edge as the completing step: fault wins.
        start_pressurize = 1'b1;
        tick(1);
        start_pressurize = 1'b0;
        tick(29);
        check("s_level9", level, 9);
        OuterClosed = 1'b0;
        tick(1);
        check("s_fault", fault, 1);
        check("s_level_hold", level, 9);
        check("s_no_done", done, 0);
        tick(1);
        check("s_no_done_later", done, 0);
        check("s_level_hold2", level, 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
